// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard/stall controller: FSM state encodings,
// register specifier width and the NOP instruction encoding.
package hazard_pkg;

    localparam int unsigned REG_W = 4;

    localparam logic [1:0] StRun     = 2'd0;
    localparam logic [1:0] StFlush   = 2'd1;
    localparam logic [1:0] StMemWait = 2'd2;

    localparam logic [15:0] NopInstr = 16'h0000;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter with synchronous active-high clear.
module hazard_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use stalls, memory-wait freezes
// and post-branch IF/ID squashing. Perf counters exist only with HAZARD_PERF_CNT_EN.
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W        = hazard_pkg::REG_W,
    parameter int unsigned FLUSH_CYCLES = 1
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W        = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] if_id_rs,
    input  logic [REG_W-1:0] if_id_rt,
    input  logic             if_id_rs_used,
    input  logic             if_id_rt_used,
    input  logic             id_ex_memread,
    input  logic [REG_W-1:0] id_ex_rd,
    input  logic             branch_taken,
    input  logic             imem_busy,
    input  logic             dmem_busy,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             if_id_flush,
    output logic             id_ex_write_en,
    output logic             id_ex_bubble,
    output logic             ex_mem_write_en,
    output logic             mem_wb_bubble,
    output logic [1:0]       state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    // Counter holds the remaining FLUSH cycles; non-zero also marks a flush pending
    // across a memory wait, since it is zero whenever the FSM is in RUN.
    localparam int unsigned FlushCntW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    logic [1:0]           state_q, state_d;
    logic [FlushCntW-1:0] fcnt_q, fcnt_d;
    logic                 load_use;

    assign load_use = id_ex_memread && (id_ex_rd != '0) &&
                      ((if_id_rs_used && (if_id_rs == id_ex_rd)) ||
                       (if_id_rt_used && (if_id_rt == id_ex_rd)));

    always_comb begin
        pc_write_en     = 1'b1;
        if_id_write_en  = 1'b1;
        if_id_flush     = 1'b0;
        id_ex_write_en  = 1'b1;
        id_ex_bubble    = 1'b0;
        ex_mem_write_en = 1'b1;
        mem_wb_bubble   = 1'b0;
        state_d         = state_q;
        fcnt_d          = fcnt_q;

        if (rst) begin
            pc_write_en     = 1'b0;
            if_id_write_en  = 1'b0;
            if_id_flush     = 1'b1;
            id_ex_write_en  = 1'b0;
            id_ex_bubble    = 1'b1;
            ex_mem_write_en = 1'b0;
            mem_wb_bubble   = 1'b1;
            state_d         = StRun;
            fcnt_d          = '0;
        end else if (dmem_busy) begin
            pc_write_en     = 1'b0;
            if_id_write_en  = 1'b0;
            id_ex_write_en  = 1'b0;
            ex_mem_write_en = 1'b0;
            mem_wb_bubble   = 1'b1;
            state_d         = StMemWait;
        end else if (state_q == StMemWait) begin
            state_d = (fcnt_q != '0) ? StFlush : StRun;
        end else if (load_use) begin
            // Branch in ID is held too and re-resolves once the load has moved on.
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_write_en = 1'b0;
            id_ex_bubble   = 1'b1;
        end else if (branch_taken) begin
            if_id_write_en = 1'b0;
            if_id_flush    = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = StFlush;
                fcnt_d  = FlushCntW'(FLUSH_CYCLES - 1);
            end else begin
                state_d = StRun;
                fcnt_d  = '0;
            end
        end else if (state_q == StFlush) begin
            if_id_write_en = 1'b0;
            if_id_flush    = 1'b1;
            if (fcnt_q <= FlushCntW'(1)) begin
                state_d = StRun;
                fcnt_d  = '0;
            end else begin
                fcnt_d = fcnt_q - 1'b1;
            end
        end else if (imem_busy) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            if_id_flush    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign state = state_q;

`ifdef HAZARD_PERF_CNT_EN
    hazard_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (!pc_write_en),
        .count (stall_cnt)
    );

    hazard_sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (if_id_flush),
        .count (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed table-driven bench for hazard_stall_unit (FLUSH_CYCLES=2).
module tb_hazard_stall_unit;

    localparam int unsigned RegW = 4;

    // Packed expected outputs:
    // {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_bubble}
    localparam logic [6:0] ODef = 7'b1101010;
    localparam logic [6:0] ORst = 7'b0010101;
    localparam logic [6:0] OLu  = 7'b0000110;
    localparam logic [6:0] OBr  = 7'b1011010;
    localparam logic [6:0] OIm  = 7'b0011010;
    localparam logic [6:0] ODm  = 7'b0000001;

    typedef struct {
        logic            rst;
        logic [RegW-1:0] rs;
        logic [RegW-1:0] rt;
        logic            rs_used;
        logic            rt_used;
        logic            memread;
        logic [RegW-1:0] rd;
        logic            br;
        logic            im;
        logic            dm;
        logic [6:0]      exp_out;
        logic [1:0]      exp_state;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [RegW-1:0] if_id_rs = '0;
    logic [RegW-1:0] if_id_rt = '0;
    logic            if_id_rs_used = 1'b0;
    logic            if_id_rt_used = 1'b0;
    logic            id_ex_memread = 1'b0;
    logic [RegW-1:0] id_ex_rd = '0;
    logic            branch_taken = 1'b0;
    logic            imem_busy = 1'b0;
    logic            dmem_busy = 1'b0;
    logic            pc_write_en, if_id_write_en, if_id_flush, id_ex_write_en;
    logic            id_ex_bubble, ex_mem_write_en, mem_wb_bubble;
    logic [1:0]      state;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0]     stall_cnt, flush_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[$];

    hazard_stall_unit #(
        .REG_W        (RegW),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .if_id_rs        (if_id_rs),
        .if_id_rt        (if_id_rt),
        .if_id_rs_used   (if_id_rs_used),
        .if_id_rt_used   (if_id_rt_used),
        .id_ex_memread   (id_ex_memread),
        .id_ex_rd        (id_ex_rd),
        .branch_taken    (branch_taken),
        .imem_busy       (imem_busy),
        .dmem_busy       (dmem_busy),
        .pc_write_en     (pc_write_en),
        .if_id_write_en  (if_id_write_en),
        .if_id_flush     (if_id_flush),
        .id_ex_write_en  (id_ex_write_en),
        .id_ex_bubble    (id_ex_bubble),
        .ex_mem_write_en (ex_mem_write_en),
        .mem_wb_bubble   (mem_wb_bubble),
        .state           (state)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input int rs, input int rt, input logic rsu,
                                input logic rtu, input logic mr, input int rd, input logic br,
                                input logic im, input logic dm, input logic [6:0] eo,
                                input logic [1:0] es);
        vec_t v;
        v.rst = r;      v.rs = RegW'(rs);   v.rt = RegW'(rt);
        v.rs_used = rsu; v.rt_used = rtu; v.memread = mr; v.rd = RegW'(rd);
        v.br = br;      v.im = im;          v.dm = dm;
        v.exp_out = eo; v.exp_state = es;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst = v.rst;
        if_id_rs = v.rs;       if_id_rt = v.rt;
        if_id_rs_used = v.rs_used; if_id_rt_used = v.rt_used;
        id_ex_memread = v.memread; id_ex_rd = v.rd;
        branch_taken = v.br;   imem_busy = v.im; dmem_busy = v.dm;
    endtask

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got outs/state %b_%b, expected %b_%b",
                     name, act[8:2], act[1:0], exp[8:2], exp[1:0]);
        end
    endtask

    task automatic step_check(input string name, input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        check(name, {pc_write_en, if_id_write_en, if_id_flush, id_ex_write_en, id_ex_bubble,
                     ex_mem_write_en, mem_wb_bubble, state}, {v.exp_out, v.exp_state});
    endtask

    initial begin
        //          rst rs rt rsu rtu mr rd br im dm  out   state
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ORst, 2'd0)); // 0 reset
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ORst, 2'd0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ODef, 2'd0)); // 2 defaults
        vecs.push_back(mk(0, 3, 5, 1, 1, 1, 3, 0, 0, 0, OLu,  2'd0)); // 3 lw r3; add r4,r3,r5
        vecs.push_back(mk(0, 3, 5, 1, 1, 0, 3, 0, 0, 0, ODef, 2'd0)); // load moved on
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, ODef, 2'd0)); // 5 rd=r0
        vecs.push_back(mk(0, 2, 7, 1, 0, 1, 7, 0, 0, 0, ODef, 2'd0)); // rt match, unused
        vecs.push_back(mk(0, 2, 7, 1, 1, 1, 7, 0, 0, 0, OLu,  2'd0)); // rt match, used
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, OIm,  2'd0)); // 8 imem busy
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, OBr,  2'd0)); // 9 branch
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, OBr,  2'd1)); // FLUSH cycle 2
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ODef, 2'd0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, OBr,  2'd0)); // 12 branch
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ODm,  2'd1)); // dmem in FLUSH
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ODm,  2'd2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ODm,  2'd2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ODef, 2'd2)); // 16 wait exit
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, OBr,  2'd1)); // FLUSH resumes
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ODef, 2'd0));
        vecs.push_back(mk(0, 3, 0, 1, 0, 1, 3, 1, 0, 0, OLu,  2'd0)); // 19 load_use+branch
        vecs.push_back(mk(0, 3, 0, 1, 0, 0, 3, 1, 0, 0, OBr,  2'd0)); // branch next cycle
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, OBr,  2'd1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ODef, 2'd0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, OBr,  2'd0)); // 23 branch > imem
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, OBr,  2'd1));
        vecs.push_back(mk(0, 4, 0, 1, 0, 1, 4, 0, 0, 1, ODm,  2'd0)); // 25 dmem > load_use
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ODef, 2'd2)); // exit to RUN
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ODef, 2'd0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, OBr,  2'd0)); // 28 branch
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ORst, 2'd1)); // rst mid-FLUSH
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ODef, 2'd0));

        foreach (vecs[i]) begin
            step_check($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset while frozen in MEM_WAIT.
        step_check("mw_enter", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ODm,  2'd0));
        step_check("mw_hold",  mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ODm,  2'd2));
        step_check("mw_rst",   mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, ORst, 2'd2));
        step_check("mw_after", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ODef, 2'd0));
`ifdef HAZARD_PERF_CNT_EN
        check("stall_cnt_after_rst", {7'd0, stall_cnt[1:0]}, 9'd0);
        n_tests++;
        if (stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL stall_cnt_zero: got %0d, expected 0", stall_cnt);
        end
        step_check("perf_im", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, OIm,  2'd0));
        step_check("perf_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ODef, 2'd0));
        n_tests++;
        if (stall_cnt !== 16'd1 || flush_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL perf_counts: got stall=%0d flush=%0d, expected 1 and 1",
                     stall_cnt, flush_cnt);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
